// File: rtl/comlink_pkg.sv
// Shared types and field layout for the com-link readout master.
package comlink_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_PUSH,
    S_GAP,
    S_FINISH
  } cl_state_e;

  // Slave DataOut layout: [15:0] payload, [21:16] read count, rest unused
  localparam int CL_DATA_LSB = 0;
  localparam int CL_DATA_W   = 16;
  localparam int CL_RCNT_LSB = 16;
  localparam int CL_RCNT_W   = 6;

  localparam logic [7:0] CL_NO_TARGET = 8'h00;

endpackage

// File: rtl/comlink_strobe_timer.sv
// Strobe-length / ack-timeout counter. Counter holds 1 while loaded and
// counts up while the strobe is active, so it reads 1 in the first strobe cycle.
module comlink_strobe_timer #(
  parameter int RD_WAIT = 3,
  parameter int USE_ACK = 0,
  parameter int ACK_TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_ack,
  output logic o_capture,
  output logic o_timeout
);

  localparam logic [3:0] LP_WAIT = 4'(RD_WAIT);
  localparam logic [3:0] LP_TMO  = 4'(ACK_TMO);

  logic [3:0] r_cnt;

  // Wait counter: reload to 1 outside the strobe, count during it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= 4'd1;
    else if (i_load) r_cnt <= 4'd1;
    else             r_cnt <= r_cnt + 4'd1;
  end

  // Capture/timeout decode; ack wins if it arrives on the timeout cycle
  always_comb begin
    o_capture = 1'b0;
    o_timeout = 1'b0;
    if (!i_load) begin
      if (USE_ACK != 0) begin
        o_capture = i_ack && (r_cnt >= 4'd1);
        o_timeout = !i_ack && (r_cnt == LP_TMO);
      end else begin
        o_capture = (r_cnt == LP_WAIT);
      end
    end
  end

endmodule

// File: rtl/comlink_reader.sv
// Com-link readout bus master: strobes one slave per word, splits the
// captured word into payload/read-count and streams it downstream.
module comlink_reader
  import comlink_pkg::*;
#(
  parameter logic [7:0] TGT_AD  = 8'hC4,
  parameter int         BURST   = 32,
  parameter int         RD_WAIT = 3,
  parameter int         USE_ACK = 0,
  parameter int         ACK_TMO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  Address,
  output logic        Read,
  input  logic [31:0] DataIn,
  input  logic        ack,
  output logic [15:0] word_out,
  output logic [5:0]  cnt_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [7:0]  words_read
);

  cl_state_e r_state, w_next;

  logic                 w_load, w_capture, w_timeout;
  logic                 r_abort, r_done, r_tmo;
  logic [CL_DATA_W-1:0] r_word;
  logic [CL_RCNT_W-1:0] r_cnt;
  logic [7:0]           r_words;
  logic                 w_unused;

  assign w_unused = ^DataIn[31:22];
  assign w_load   = (r_state != S_STROBE);

  comlink_strobe_timer #(
    .RD_WAIT (RD_WAIT),
    .USE_ACK (USE_ACK),
    .ACK_TMO (ACK_TMO)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_ack     (ack),
    .o_capture (w_capture),
    .o_timeout (w_timeout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and state-decoded bus/stream outputs
  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    Address    = (r_state != S_IDLE) ? TGT_AD : CL_NO_TARGET;
    Read       = (r_state == S_STROBE);
    word_valid = (r_state == S_PUSH);
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETUP;
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: begin
        if (w_timeout)      w_next = S_FINISH;
        else if (w_capture) w_next = S_PUSH;
      end
      S_PUSH:   if (word_ready) w_next = S_GAP;
      S_GAP:    w_next = ((r_words == 8'(BURST)) || r_abort) ? S_FINISH : S_STROBE;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: capture, word count, abort latch, sticky timeout, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort <= 1'b0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_words <= '0;
    end else begin
      // registered so it rises on the same edge that busy falls
      r_done <= (r_state == S_FINISH);
      if (r_state == S_IDLE) begin
        r_abort <= start & abort;
        if (start) begin
          r_words <= '0;
          r_tmo   <= 1'b0;
        end
      end else if (abort) begin
        r_abort <= 1'b1;
      end
      if (r_state == S_STROBE) begin
        if (w_timeout) begin
          r_tmo <= 1'b1;
        end else if (w_capture) begin
          r_word <= DataIn[CL_DATA_LSB +: CL_DATA_W];
          r_cnt  <= DataIn[CL_RCNT_LSB +: CL_RCNT_W];
        end
      end
      if (r_state == S_PUSH && word_ready) r_words <= r_words + 8'd1;
    end
  end

  assign word_out    = r_word;
  assign cnt_out     = r_cnt;
  assign done        = r_done;
  assign timeout_err = r_tmo;
  assign words_read  = r_words;

endmodule

// File: doc/comlink_reader.md
# comlink_reader

Bus-master end of the com-link readout bus. On `start`, it addresses one readout slave, issues one `Read` strobe per word and captures the 32-bit `DataIn` word. It splits each captured word into a 16-bit payload and the slave's 6-bit read count, then hands both downstream on a valid/ready stream. It sits between the com-link slaves (e.g. TDC histogram FIFOs at address `8'hC4`) and the readout packer.

## Interface
- `TGT_AD`, `8'hC4`: slave address driven while busy.
- `BURST`, `32`: words read per `start` (1..255).
- `RD_WAIT`, `3`: cycles `Read` is held high before capture (1..15).
- `USE_ACK`, `0`: 1 = capture on `ack`, with a timeout; 0 = capture after `RD_WAIT` cycles.
- `ACK_TMO`, `15`: cycles allowed for `ack` when `USE_ACK`=1 (≥ `RD_WAIT`).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a burst; ignored while `busy`.
- `abort` in 1: ends the burst after the current word.
- `Address` out 8: `TGT_AD` while busy, otherwise `8'h00` (no target).
- `Read` out 1: read strobe to the slave.
- `DataIn` in 32: slave `DataOut`; [15:0] payload, [21:16] RCNT, [31:22] ignored.
- `ack` in 1: slave acknowledge (only used when `USE_ACK`=1).
- `word_out` out 16: captured payload.
- `cnt_out` out 6: captured RCNT.
- `word_valid` out 1 / `word_ready` in 1: downstream handshake.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst end.
- `timeout_err` out 1: sticky; cleared by the next accepted `start`.
- `words_read` out 8: words delivered in the current or last burst.

## Operation
- States: IDLE, SETUP, STROBE, PUSH, GAP, FINISH.
- **IDLE:** `start` → SETUP. Clears `words_read` and `timeout_err`, and sets `busy`.
- **SETUP:** 1 cycle with `Address`=`TGT_AD` and `Read`=0 (address setup) → STROBE.
- **STROBE:** `Read`=1 and a wait counter runs from 1.
  - `USE_ACK`=0: on counter = `RD_WAIT`, capture `DataIn`[15:0] and [21:16] → PUSH.
  - `USE_ACK`=1: capture on the first cycle with `ack`=1 and counter ≥ 1. If the counter reaches `ACK_TMO` without `ack`, set `timeout_err` and go to FINISH with no capture.
- **PUSH:** `Read`=0 and `word_valid`=1. Hold `word_out`/`cnt_out` stable until `word_ready`. On the handshake, increment `words_read` → GAP.
- **GAP:** 1 cycle with `Read`=0, so the slave's repeat-read block clears.
  - If `words_read` = `BURST` or `abort` was latched: → FINISH.
  - Otherwise: → STROBE.
- **FINISH:** pulse `done` for 1 cycle, clear `busy` → IDLE.
- `abort` is latched in any busy state and cleared in IDLE. Latching it never truncates a word already strobed or pending in PUSH.
- `Read` is never high for two consecutive words without at least 2 low cycles between them (PUSH ≥ 1 cycle plus GAP).
- `start` together with `abort` in IDLE: the burst starts and ends after 1 word.
- Counter widths: wait counter 4 bit, `words_read` 8 bit. No wrap is possible given the parameter ranges.

## Timing
- Reset values: `Address`=0, `Read`=0, `word_out`=0, `cnt_out`=0, `word_valid`=0, `busy`=0, `done`=0, `timeout_err`=0, `words_read`=0, state IDLE.
- `start` sampled at edge 0:
  - `busy`/`Address` valid after edge 0.
  - `Read` high after edge 1, for `RD_WAIT` cycles.
  - Capture at edge 1+`RD_WAIT`; `word_valid` high in the following cycle.
- Per-word minimum period with `word_ready`=1: `RD_WAIT`+2 cycles.
- Burst minimum: 1 + `BURST`·(`RD_WAIT`+2) + 1 cycles, from `start` to `done`.
- `done` coincides with `busy` falling. `words_read` is stable from `done` onward.
- Reset mid-burst: all outputs return to reset values asynchronously. A pending word is discarded and not counted.

## Structure
- Shared package `comlink_pkg`:
  - State enum.
  - Field constants: `CL_DATA_LSB`=0, `CL_DATA_W`=16, `CL_RCNT_LSB`=16, `CL_RCNT_W`=6.
  - `CL_NO_TARGET`=`8'h00`.
- One sub-module, `comlink_strobe_timer`: strobe-length/ack-timeout counter. Inputs: load, `ack`. Outputs: `capture`, `timeout`.

## Test plan
- Default parameters, `word_ready`=1, slave model returning {10'b0, RCNT=n, 16'hA000+n}: 32 words `A000..A01F` with `cnt_out` 0..31. `done` at cycle 1+32·5+1=162; `words_read`=32.
- `word_ready` low for 7 cycles on word 3: `word_out` held stable. `Read` stays low throughout; no extra slave reads occur.
- `abort` pulsed during word 5's STROBE: words 0..5 are delivered, `words_read`=6, `done` fires.
- `USE_ACK`=1, `ack` never asserted: `Read` is high for 15 cycles, `timeout_err`=1, `done` fires, no `word_valid`. The next `start` clears `timeout_err`.
- `rst` asserted while in PUSH: outputs go to 0 immediately. A new `start` after release restarts with `words_read` beginning from 0.
- `start` pulses while `busy`: ignored. `BURST`=1 with `start` and `abort` together: exactly 1 word is delivered.
